soc_timer_axil: RTL and testbench
=================================

# soc_timer_axil

AXI4-Lite slave timer peripheral occupying the SoC Timer window (base 0x1800_0000, 4 KiB). It sits directly downstream of the SoC crossbar's Timer master port, behind the AXI-to-AXI-Lite conversion. It provides a free-running, prescaled 32-bit counter with a compare match and a level interrupt routed to a PLIC source.

## Interface
- AddrWidth, 64: AXI-Lite address width. Only addr[11:2] are decoded; addr[1:0] are ignored.
- DataWidth, 32: data width. Fixed at 32; any other value is a synthesis error.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- awaddr_i  in  AddrWidth  write address.
- awvalid_i / awready_o  in/out  1  AW handshake.
- wdata_i  in  32  write data.
- wstrb_i  in  4  byte strobes.
- wvalid_i / wready_o  in/out  1  W handshake.
- bresp_o  out  2  write response.
- bvalid_o / bready_i  out/in  1  B handshake.
- araddr_i  in  AddrWidth  read address.
- arvalid_i / arready_o  in/out  1  AR handshake.
- rdata_o  out  32  read data.
- rresp_o  out  2  read response.
- rvalid_o / rready_i  out/in  1  R handshake.
- irq_o  out  1  level interrupt, equal to STATUS.MATCH & CTRL.IRQ_EN.

## Operation
- Register map (offset[11:0]):
  - 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0.
  - 0x04 PRESCALE: 32-bit.
  - 0x08 COUNT: 32-bit.
  - 0x0C COMPARE: 32-bit, reset value 0xFFFF_FFFF.
  - 0x10 STATUS: bit0 MATCH, write-1-to-clear.
- Any other offset returns SLVERR (2'b10): writes have no effect, reads return rdata 0. Mapped offsets return OKAY (2'b00).
- wstrb is honoured bytewise for all registers, including the STATUS W1C bit.
- Prescaler: when EN=1, the internal counter pcnt increments every cycle. When pcnt==PRESCALE, pcnt←0 and a tick is generated, so the tick period is PRESCALE+1 cycles.
- Writing CTRL with EN=0 clears pcnt.
- On each tick:
  - If COUNT==COMPARE, MATCH←1.
  - Then, if AUTO_RELOAD=1 and a match occurred, COUNT←0; otherwise COUNT←COUNT+1, mod 2^32 (0xFFFF_FFFF wraps to 0).
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick: the software value wins and the increment is dropped. The match check still uses the pre-write COUNT.
  - A W1C of MATCH in the same cycle as a new match: set wins.
  - Writing PRESCALE below the current pcnt: the next cycle compares against the new value; pcnt keeps incrementing and wraps at 2^32 before ticking.

## Timing
- Reset: all registers 0 except COMPARE=0xFFFF_FFFF. pcnt=0. All outputs 0: bvalid_o, rvalid_o, awready_o, wready_o, arready_o, irq_o, rdata_o, bresp_o, rresp_o.
- Write channel:
  - awready_o = wready_o = awvalid_i & wvalid_i & ~bvalid_o (combinational). AW and W are accepted only together.
  - The register update occurs on the accepting edge.
  - bvalid_o rises the following cycle and is held stable with bresp_o until bready_i.
  - At most one write is outstanding.
- Read channel:
  - arready_o = ~rvalid_o.
  - rdata_o/rresp_o are registered at AR acceptance: latency 1 cycle, values reflect register state before that edge.
  - rvalid_o and rdata_o/rresp_o are held until rready_i.
- Read and write may be accepted in the same cycle. A read of a register written in that cycle returns the old value.
- irq_o is a function of flops only: it rises the cycle after the MATCH-setting tick edge (no combinational input path).
- Reset asserted mid-transaction: pending B/R are dropped immediately and all state returns to reset values.

## Configuration
- SOC_TIMER_PRESCALER_EN defined: the PRESCALE register and pcnt exist as described.
- SOC_TIMER_PRESCALER_EN undefined:
  - No pcnt flop.
  - Tick = EN every cycle.
  - 0x04 reads 0, and writes return OKAY with no effect.

## Test plan
- Reset -> COMPARE reads 0xFFFF_FFFF, other registers read 0, irq_o=0.
- With prescaler built in: PRESCALE=3, COMPARE=2, CTRL=0x3 -> MATCH set on the 3rd tick, 12 cycles after enable; irq_o=1 one cycle later; COUNT continues to 3.
- AUTO_RELOAD: CTRL=0x7, COMPARE=5, PRESCALE=0 -> COUNT cycles 0..5,0..; MATCH set at the first wrap.
- W1C: write STATUS=0x1 with wstrb=0x1 while no tick -> MATCH=0, irq_o falls. The same write coincident with a match -> MATCH stays 1.
- Read offset 0x20 -> rresp=SLVERR, rdata=0. Write 0x20 -> bresp=SLVERR, no register changes.
- Backpressure: hold bready_i=0 for 5 cycles -> bvalid_o stable, awready_o=0 for a second write. The second write is accepted the cycle after B completes.

Source files
------------

// File: rtl/soc_timer_axil.sv
// soc_timer_axil: AXI4-Lite timer peripheral with a free-running 32-bit
// counter, optional prescaler, compare match and a level interrupt.
//
// Build option: define SOC_TIMER_PRESCALER_EN to include the PRESCALE
// register and the internal prescale counter. Without it the counter
// advances every cycle while enabled and offset 0x04 is a read-as-zero,
// write-ignored location that still answers OKAY.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   aw*/w*/b*                   AXI4-Lite write address/data/response
//   ar*/r*                      AXI4-Lite read address/data
//   irq_o                       level interrupt = STATUS.MATCH & CTRL.IRQ_EN
//
// Register map (addr[11:2] decoded, addr[1:0] and upper bits ignored):
//   0x00 CTRL     bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD
//   0x04 PRESCALE tick period = PRESCALE+1 cycles
//   0x08 COUNT
//   0x0C COMPARE  resets to 0xFFFF_FFFF
//   0x10 STATUS   bit0 MATCH, write-1-to-clear
//   other offsets respond SLVERR, reads return 0

module soc_timer_axil #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   awaddr_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic [1:0]             bresp_o,
  output logic                   bvalid_o,
  input  logic                   bready_i,
  input  logic [AddrWidth-1:0]   araddr_i,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [1:0]             rresp_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic                   irq_o
);

  localparam int unsigned RegIdxW   = 10;
  localparam int unsigned StrbW     = DataWidth / 8;
  localparam int unsigned CtrlW     = 3;
  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlIrqEn = 1;
  localparam int unsigned CtrlAuto  = 2;

  localparam logic [RegIdxW-1:0] IdxCtrl     = RegIdxW'(0);
  localparam logic [RegIdxW-1:0] IdxPrescale = RegIdxW'(1);
  localparam logic [RegIdxW-1:0] IdxCount    = RegIdxW'(2);
  localparam logic [RegIdxW-1:0] IdxCompare  = RegIdxW'(3);
  localparam logic [RegIdxW-1:0] IdxStatus   = RegIdxW'(4);

  localparam logic [1:0]           RespOkay   = 2'b00;
  localparam logic [1:0]           RespSlvErr = 2'b10;
  localparam logic [DataWidth-1:0] CompareRst = DataWidth'(32'hFFFF_FFFF);

  // Only a 32-bit data path is supported.
  if (DataWidth != 32) begin : g_dw_check
    $error("soc_timer_axil: DataWidth must be 32");
  end

  // Byte-lane merge of a write into the current register value.
  function automatic logic [DataWidth-1:0] byte_merge(
    input logic [DataWidth-1:0] cur,
    input logic [DataWidth-1:0] wr,
    input logic [StrbW-1:0]     strb
  );
    logic [DataWidth-1:0] res;
    res = cur;
    for (int unsigned i = 0; i < StrbW; i++) begin
      if (strb[i]) res[8*i +: 8] = wr[8*i +: 8];
    end
    return res;
  endfunction

  // Architectural state
  logic [CtrlW-1:0]     ctrl_q, ctrl_d;
  logic [DataWidth-1:0] count_q, count_d;
  logic [DataWidth-1:0] compare_q, compare_d;
  logic                 match_q, match_d;
  logic                 irq_q, irq_d;
`ifdef SOC_TIMER_PRESCALER_EN
  logic [DataWidth-1:0] prescale_q, prescale_d;
  logic [DataWidth-1:0] pcnt_q, pcnt_d;
`endif

  // Bus channel state
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 arready_q, arready_d;

  logic               wr_fire_c, rd_fire_c;
  logic [RegIdxW-1:0] wr_idx_c, rd_idx_c;
  logic               wr_mapped_c, rd_mapped_c;
  logic               tick_c, match_evt_c, w1c_c;
  logic [DataWidth-1:0] rd_data_c;

  // Upper address bits and byte offset are intentionally not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr_i[AddrWidth-1:12], awaddr_i[1:0],
                              araddr_i[AddrWidth-1:12], araddr_i[1:0]};

  assign wr_fire_c   = awvalid_i & wvalid_i & ~bvalid_q;
  assign rd_fire_c   = arvalid_i & arready_q;
  assign wr_idx_c    = awaddr_i[11:2];
  assign rd_idx_c    = araddr_i[11:2];
  assign wr_mapped_c = (wr_idx_c <= IdxStatus);
  assign rd_mapped_c = (rd_idx_c <= IdxStatus);

`ifdef SOC_TIMER_PRESCALER_EN
  assign tick_c = ctrl_q[CtrlEn] & (pcnt_q == prescale_q);
`else
  assign tick_c = ctrl_q[CtrlEn];
`endif

  // Match is judged on the pre-write COUNT, even if software writes it now.
  assign match_evt_c = tick_c & (count_q == compare_q);
  assign w1c_c       = wr_fire_c & (wr_idx_c == IdxStatus) & wstrb_i[0] & wdata_i[0];

  // Read mux sees register state before the accepting edge.
  always_comb begin
    rd_data_c = '0;
    case (rd_idx_c)
      IdxCtrl:     rd_data_c = DataWidth'(ctrl_q);
`ifdef SOC_TIMER_PRESCALER_EN
      IdxPrescale: rd_data_c = prescale_q;
`endif
      IdxCount:    rd_data_c = count_q;
      IdxCompare:  rd_data_c = compare_q;
      IdxStatus:   rd_data_c = DataWidth'(match_q);
      default:     rd_data_c = '0;
    endcase
  end

  // Next-state logic for registers and bus channels.
  always_comb begin
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;
    irq_d      = irq_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    arready_d  = arready_q;
`ifdef SOC_TIMER_PRESCALER_EN
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    if (ctrl_q[CtrlEn]) begin
      pcnt_d = (pcnt_q == prescale_q) ? '0 : pcnt_q + DataWidth'(1);
    end
`endif

    if (tick_c) begin
      count_d = (ctrl_q[CtrlAuto] & match_evt_c) ? '0 : count_q + DataWidth'(1);
    end

    // A software write to COUNT overrides the tick increment.
    if (wr_fire_c) begin
      case (wr_idx_c)
        IdxCtrl:     if (wstrb_i[0]) ctrl_d = wdata_i[CtrlW-1:0];
`ifdef SOC_TIMER_PRESCALER_EN
        IdxPrescale: prescale_d = byte_merge(prescale_q, wdata_i, wstrb_i);
`endif
        IdxCount:    count_d   = byte_merge(count_q, wdata_i, wstrb_i);
        IdxCompare:  compare_d = byte_merge(compare_q, wdata_i, wstrb_i);
        default:     ;
      endcase
    end

`ifdef SOC_TIMER_PRESCALER_EN
    if (wr_fire_c && (wr_idx_c == IdxCtrl) && !ctrl_d[CtrlEn]) begin
      pcnt_d = '0;
    end
`endif

    // A new match beats a simultaneous clear.
    match_d = (match_q & ~w1c_c) | match_evt_c;
    irq_d   = match_d & ctrl_d[CtrlIrqEn];

    if (wr_fire_c) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_mapped_c ? RespOkay : RespSlvErr;
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end

    if (rd_fire_c) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_c;
      rresp_d  = rd_mapped_c ? RespOkay : RespSlvErr;
    end else if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end

    // arready tracks ~rvalid but stays low while in reset.
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= '0;
      count_q    <= '0;
      compare_q  <= CompareRst;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      arready_q  <= 1'b0;
`ifdef SOC_TIMER_PRESCALER_EN
      prescale_q <= '0;
      pcnt_q     <= '0;
`endif
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      arready_q  <= arready_d;
`ifdef SOC_TIMER_PRESCALER_EN
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
`endif
    end
  end

  assign awready_o = wr_fire_c;
  assign wready_o  = wr_fire_c;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_soc_timer_axil.sv
// Bench for soc_timer_axil: directed register/handshake scenarios followed by
// random AXI-Lite traffic, all checked against a register-level reference
// model that follows the timer rules cycle by cycle.
`timescale 1ns/1ps
module tb_soc_timer_axil;

`ifdef SOC_TIMER_PRESCALER_EN
  localparam bit PrescEn = 1'b1;
`else
  localparam bit PrescEn = 1'b0;
`endif

  localparam logic [11:0] OffCtrl     = 12'h000;
  localparam logic [11:0] OffPrescale = 12'h004;
  localparam logic [11:0] OffCount    = 12'h008;
  localparam logic [11:0] OffCompare  = 12'h00C;
  localparam logic [11:0] OffStatus   = 12'h010;
  localparam logic [11:0] OffBad      = 12'h020;
  localparam logic [63:0] Base        = 64'h0000_0000_1800_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [63:0] awaddr_i, araddr_i;
  logic        awvalid_i, awready_o, wvalid_i, wready_o;
  logic [31:0] wdata_i, rdata_o;
  logic [3:0]  wstrb_i;
  logic [1:0]  bresp_o, rresp_o;
  logic        bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i, irq_o;

  always #5 clk_i = ~clk_i;

  soc_timer_axil dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .irq_o(irq_o)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned cyc     = 0;
  int unsigned wr_cyc  = 0;

  // Reference model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_prescale, m_pcnt, m_count, m_compare, m_rdata;
  logic        m_match, m_bvalid, m_rvalid, m_arready;
  logic [1:0]  m_bresp, m_rresp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic fail_timeout(input string tag);
    n_total++;
    $error("FAIL %s timed out waiting for handshake", tag);
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_prescale = '0; m_pcnt = '0; m_count = '0;
    m_compare = 32'hFFFF_FFFF; m_match = 1'b0; m_rdata = '0;
    m_bvalid = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0;
    m_bresp = '0; m_rresp = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wr,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = wr[8*i +: 8];
    return r;
  endfunction

  // Register image as seen by a read of the given offset.
  task automatic model_read(input logic [11:0] off, output logic [31:0] d, output logic [1:0] r);
    d = '0; r = 2'b00;
    case (off)
      OffCtrl:     d = {29'd0, m_ctrl};
      OffPrescale: d = PrescEn ? m_prescale : 32'd0;
      OffCount:    d = m_count;
      OffCompare:  d = m_compare;
      OffStatus:   d = {31'd0, m_match};
      default:     r = 2'b10;
    endcase
  endtask

  task automatic check_outputs();
    check("bvalid", bvalid_o, m_bvalid);
    check("rvalid", rvalid_o, m_rvalid);
    check("arready", arready_o, m_arready);
    check("awready", awready_o, awvalid_i && wvalid_i && !m_bvalid);
    check("wready", wready_o, awvalid_i && wvalid_i && !m_bvalid);
    check("irq", irq_o, m_match && m_ctrl[1]);
    if (m_bvalid) check("bresp", bresp_o, m_bresp);
    if (m_rvalid) begin
      check("rdata", rdata_o, m_rdata);
      check("rresp", rresp_o, m_rresp);
    end
  endtask

  // Advance one clock: evaluate the timer rules on the current inputs, then
  // commit at the edge and compare outputs shortly after it.
  task automatic cycle();
    logic [11:0] woff, roff;
    bit          wfire, rfire, tick, hit, clr;
    logic [2:0]  n_ctrl;
    logic [31:0] n_prescale, n_pcnt, n_count, n_compare, n_rdata;
    logic        n_match, n_bvalid, n_rvalid;
    logic [1:0]  n_bresp, n_rresp;
    if (!rst_ni) begin
      @(posedge clk_i);
      cyc++;
      #1;
    end else begin
      wfire = awvalid_i && wvalid_i && !m_bvalid;
      rfire = arvalid_i && m_arready;
      woff  = {awaddr_i[11:2], 2'b00};
      roff  = {araddr_i[11:2], 2'b00};
      n_ctrl = m_ctrl; n_prescale = m_prescale; n_pcnt = m_pcnt;
      n_count = m_count; n_compare = m_compare;
      n_bvalid = m_bvalid; n_bresp = m_bresp;
      n_rvalid = m_rvalid; n_rdata = m_rdata; n_rresp = m_rresp;
      clr = 1'b0;
      tick = m_ctrl[0] && (!PrescEn || (m_pcnt == m_prescale));
      hit  = tick && (m_count == m_compare);
      if (tick) n_count = (m_ctrl[2] && hit) ? 32'd0 : m_count + 32'd1;
      if (PrescEn && m_ctrl[0]) n_pcnt = (m_pcnt == m_prescale) ? 32'd0 : m_pcnt + 32'd1;
      if (wfire) begin
        case (woff)
          OffCtrl: begin
            if (wstrb_i[0]) n_ctrl = wdata_i[2:0];
            if (!n_ctrl[0]) n_pcnt = 32'd0;
          end
          OffPrescale: if (PrescEn) n_prescale = merge(m_prescale, wdata_i, wstrb_i);
          OffCount:    n_count   = merge(m_count, wdata_i, wstrb_i);
          OffCompare:  n_compare = merge(m_compare, wdata_i, wstrb_i);
          OffStatus:   clr = wstrb_i[0] && wdata_i[0];
          default: ;
        endcase
        n_bvalid = 1'b1;
        n_bresp  = (woff <= OffStatus) ? 2'b00 : 2'b10;
        wr_cyc   = cyc + 1;
      end else if (m_bvalid && bready_i) begin
        n_bvalid = 1'b0;
      end
      n_match = (m_match && !clr) || hit;
      if (rfire) begin
        n_rvalid = 1'b1;
        model_read(roff, n_rdata, n_rresp);
      end else if (m_rvalid && rready_i) begin
        n_rvalid = 1'b0;
      end
      @(posedge clk_i);
      cyc++;
      m_ctrl = n_ctrl; m_prescale = n_prescale; m_pcnt = n_pcnt;
      m_count = n_count; m_compare = n_compare; m_match = n_match;
      m_bvalid = n_bvalid; m_bresp = n_bresp;
      m_rvalid = n_rvalid; m_rdata = n_rdata; m_rresp = n_rresp;
      m_arready = !n_rvalid;
      #1;
      check_outputs();
    end
  endtask

  // Present a write and hold it until accepted; valid is left asserted.
  task automatic aw_issue(input logic [11:0] off, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit acc;
    int n = 0;
    awaddr_i = Base | 64'(off); wdata_i = data; wstrb_i = strb;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    do begin
      acc = !m_bvalid;
      cycle();
      n++;
    end while (!acc && n < 50);
    if (!acc) fail_timeout("aw_accept");
    resp = bresp_o;
  endtask

  task automatic aw_done();
    int n = 0;
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    while (m_bvalid && n < 50) begin cycle(); n++; end
    if (m_bvalid) fail_timeout("b_complete");
  endtask

  task automatic axi_write(input logic [11:0] off, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp;
    aw_issue(off, data, strb, resp);
    aw_done();
  endtask

  task automatic axi_read(input logic [11:0] off, output logic [31:0] data, output logic [1:0] resp);
    bit acc;
    int n = 0;
    araddr_i = Base | 64'(off); arvalid_i = 1'b1; rready_i = 1'b1;
    do begin
      acc = m_arready;
      cycle();
      n++;
    end while (!acc && n < 50);
    arvalid_i = 1'b0;
    if (!acc) fail_timeout("ar_accept");
    data = rdata_o; resp = rresp_o;
    cycle();
  endtask

  function automatic logic [31:0] rand_data(input logic [11:0] off);
    case (off)
      OffCtrl:     return ($urandom_range(0, 3) != 0) ? (32'($urandom) | 32'd1) : 32'($urandom);
      OffPrescale: return 32'($urandom_range(0, 3));
      OffCount, OffCompare:
        return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                           : 32'($urandom_range(0, 12));
      OffStatus:   return 32'($urandom_range(0, 1));
      default:     return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [11:0] offs [8] = '{OffCtrl, OffPrescale, OffCount, OffCompare,
                             OffStatus, 12'h014, OffBad, 12'hFFC};
    bit aw_pend, ar_pend, aw_acc, ar_acc;
    int n;
    logic [11:0] o;

    rst_ni = 1'b0;
    awaddr_i = '0; araddr_i = '0; wdata_i = '0; wstrb_i = '0;
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    bready_i = 1'b1; rready_i = 1'b1;
    model_reset();
    #1;
    check("rst_bvalid", bvalid_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_arready", arready_o, 0);
    check("rst_awready", awready_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_bresp", bresp_o, 0);
    check("rst_rresp", rresp_o, 0);
    cycle(); cycle();
    rst_ni = 1'b1;
    cycle();

    // Reset values of the register file
    axi_read(OffCompare, d, r);  check("rst_compare", d, 32'hFFFF_FFFF);
    axi_read(OffCtrl, d, r);     check("rst_ctrl", d, 0);
    axi_read(OffCount, d, r);    check("rst_count", d, 0);
    axi_read(OffStatus, d, r);   check("rst_status", d, 0);
    axi_read(OffPrescale, d, r); check("rst_prescale", d, 0);

    // Compare match: third tick sets MATCH, COUNT carries on to 3
    axi_write(OffPrescale, 32'd3, 4'hF);
    axi_write(OffCompare, 32'd2, 4'hF);
    axi_write(OffCtrl, 32'd3, 4'hF);
    n = 0;
    while (!irq_o && n < 200) begin cycle(); n++; end
    check("match_latency", 32'(cyc - wr_cyc), PrescEn ? 32'd12 : 32'd3);
    axi_read(OffCount, d, r);    check("count_after_match", d, 3);
    axi_write(OffCtrl, 32'd2, 4'hF);

    // W1C: wrong lane has no effect, lane 0 clears
    axi_write(OffStatus, 32'd1, 4'h2);
    axi_read(OffStatus, d, r);   check("w1c_wrong_lane", d, 1);
    axi_write(OffStatus, 32'd1, 4'h1);
    axi_read(OffStatus, d, r);   check("w1c_clear", d, 0);
    check("irq_after_w1c", irq_o, 0);

    // W1C landing on the same edge as a new match: MATCH stays set
    axi_write(OffPrescale, 32'd0, 4'hF);
    axi_write(OffCount, 32'd0, 4'hF);
    axi_write(OffCompare, 32'd1, 4'hF);
    aw_issue(OffCtrl, 32'd3, 4'hF, r);
    aw_issue(OffStatus, 32'd1, 4'h1, r);
    aw_done();
    axi_write(OffCtrl, 32'd2, 4'hF);
    axi_read(OffStatus, d, r);   check("w1c_vs_set", d, 1);
    axi_write(OffStatus, 32'd1, 4'hF);

    // Unmapped offset: SLVERR both ways, no side effects
    axi_read(OffBad, d, r);
    check("bad_rd_resp", 32'(r), 32'd2);
    check("bad_rd_data", d, 0);
    aw_issue(OffBad, 32'hFFFF_FFFF, 4'hF, r);
    aw_done();
    check("bad_wr_resp", 32'(r), 32'd2);
    axi_read(OffCtrl, d, r);     check("bad_wr_ctrl", d, 2);

    // Write response backpressure with a second write waiting
    bready_i = 1'b0;
    aw_issue(OffCompare, 32'h1234_5678, 4'hF, r);
    awaddr_i = Base | 64'(OffPrescale); wdata_i = 32'd7; wstrb_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_bvalid", bvalid_o, 1);
      check("bp_bresp", bresp_o, 0);
      check("bp_awready", awready_o, 0);
    end
    bready_i = 1'b1;
    cycle();
    check("bp_b_done", bvalid_o, 0);
    check("bp_awready_after", awready_o, 1);
    cycle();
    check("bp_second_b", bvalid_o, 1);
    aw_done();
    axi_read(OffCompare, d, r);  check("bp_compare", d, 32'h1234_5678);
    axi_read(OffPrescale, d, r); check("bp_prescale", d, PrescEn ? 32'd7 : 32'd0);
    axi_write(OffPrescale, 32'd0, 4'hF);

    // Random concurrent traffic
    aw_pend = 1'b0; ar_pend = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!aw_pend && $urandom_range(0, 2) == 0) begin
        o = offs[$urandom_range(0, 7)];
        awaddr_i = {32'($urandom), 20'd0, o[11:2], 2'($urandom)};
        wdata_i = rand_data(o);
        wstrb_i = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        awvalid_i = 1'b1; wvalid_i = 1'b1; aw_pend = 1'b1;
      end
      if (!ar_pend && $urandom_range(0, 2) == 0) begin
        o = offs[$urandom_range(0, 7)];
        araddr_i = {32'($urandom), 20'd0, o[11:2], 2'($urandom)};
        arvalid_i = 1'b1; ar_pend = 1'b1;
      end
      bready_i = ($urandom_range(0, 3) != 0);
      rready_i = ($urandom_range(0, 3) != 0);
      aw_acc = aw_pend && !m_bvalid;
      ar_acc = ar_pend && m_arready;
      cycle();
      if (aw_acc) begin awvalid_i = 1'b0; wvalid_i = 1'b0; aw_pend = 1'b0; end
      if (ar_acc) begin arvalid_i = 1'b0; ar_pend = 1'b0; end
    end
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    bready_i = 1'b1; rready_i = 1'b1;
    cycle(); cycle();

    // Reset in the middle of pending B and R
    axi_write(OffCtrl, 32'd0, 4'hF);
    axi_write(OffStatus, 32'd1, 4'hF);
    bready_i = 1'b0; rready_i = 1'b0;
    aw_issue(OffCount, 32'h55, 4'hF, r);
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    araddr_i = Base | 64'(OffCount); arvalid_i = 1'b1;
    n = 0;
    while (!m_arready && n < 50) begin cycle(); n++; end
    cycle();
    arvalid_i = 1'b0;
    check("pre_rst_bvalid", bvalid_o, 1);
    check("pre_rst_rvalid", rvalid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("mid_rst_bvalid", bvalid_o, 0);
    check("mid_rst_rvalid", rvalid_o, 0);
    check("mid_rst_arready", arready_o, 0);
    check("mid_rst_rdata", rdata_o, 0);
    check("mid_rst_irq", irq_o, 0);
    cycle(); cycle();
    rst_ni = 1'b1;
    bready_i = 1'b1; rready_i = 1'b1;
    cycle();
    axi_read(OffCompare, d, r);  check("post_rst_compare", d, 32'hFFFF_FFFF);
    axi_read(OffCount, d, r);    check("post_rst_count", d, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
